// File: rtl/axi_write_rx_pkg.sv
// Shared constants and types for the AXI4 MCTP-over-PCIe VDM write responder:
// packet-position encodings, header field positions, response and error codes.
package axi_write_rx_pkg;

  // SOM/EOM packet-position encodings from header[127:126]
  localparam logic [1:0] M_PKT  = 2'b00;
  localparam logic [1:0] L_PKT  = 2'b01;
  localparam logic [1:0] S_PKT  = 2'b10;
  localparam logic [1:0] SG_PKT = 2'b11;

  // Bit positions (LSB) of the header fields in beat 0
  localparam int HDR_FMT_LSB  = 5;
  localparam int HDR_TYPE_LSB = 3;
  localparam int HDR_CODE_LSB = 56;
  localparam int HDR_VID_LSB  = 80;
  localparam int HDR_ASM_LSB  = 120;  // {som_eom, seq, tag} occupy [127:120]

  localparam logic [2:0] FMT_VDM      = 3'b011;
  localparam logic [1:0] TYPE_MSG     = 2'b10;
  localparam logic [7:0] MSG_CODE_VDM = 8'h7F;

  localparam logic [2:0] AWSIZE_32B = 3'd5;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ASM_ERR_NONE    = 3'd0,
    ASM_ERR_RESTART = 3'd1,
    ASM_ERR_SEQ     = 3'd2,
    ASM_ERR_TAG     = 3'd3,
    ASM_ERR_ORPHAN  = 3'd4
  } asm_err_t;

  typedef enum logic {
    ASM_IDLE,
    ASM_ACTIVE
  } asm_state_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } bus_state_t;

endpackage

// File: rtl/axi_write_rx_asm_check.sv
// MCTP message assembly tracker: follows SOM/EOM, packet sequence and tag
// across bursts and reports completion or an assembly error code per packet.
module mctp_asm_check
  import axi_write_rx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_eval,
  input  logic [1:0] i_som_eom,
  input  logic [1:0] i_seq,
  input  logic [3:0] i_tag,
  output logic       o_msg_done,
  output logic [2:0] o_asm_err
);

  asm_state_t state;
  logic [3:0] cur_tag;
  logic [1:0] exp_seq;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ASM_IDLE;
      cur_tag    <= '0;
      exp_seq    <= '0;
      o_msg_done <= 1'b0;
      o_asm_err  <= ASM_ERR_NONE;
    end else begin
      o_msg_done <= 1'b0;
      o_asm_err  <= ASM_ERR_NONE;
      if (i_eval) begin
        case (i_som_eom)
          S_PKT: begin
            if (state == ASM_ACTIVE) o_asm_err <= ASM_ERR_RESTART;
            cur_tag <= i_tag;
            exp_seq <= i_seq + 2'd1;
            state   <= ASM_ACTIVE;
          end
          M_PKT, L_PKT: begin
            if (state != ASM_ACTIVE) begin
              o_asm_err <= ASM_ERR_ORPHAN;
              state     <= ASM_IDLE;
            end else if (i_tag != cur_tag) begin
              o_asm_err <= ASM_ERR_TAG;
              state     <= ASM_IDLE;
            end else if (i_seq != exp_seq) begin
              o_asm_err <= ASM_ERR_SEQ;
              state     <= ASM_IDLE;
            end else begin
              exp_seq <= exp_seq + 2'd1;
              if (i_som_eom == L_PKT) begin
                o_msg_done <= 1'b1;
                state      <= ASM_IDLE;
              end
            end
          end
          SG_PKT: begin
            if (state == ASM_ACTIVE) o_asm_err <= ASM_ERR_RESTART;
            o_msg_done <= 1'b1;
            state      <= ASM_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/axi_write_rx.sv
// AXI4 write responder terminating MCTP-over-PCIe VDM bursts; forwards beats
// downstream, validates the beat-0 header and tracks message assembly.
// Define AXI_WRITE_RX_STATS_EN to add saturating message/error/SLVERR counters.
module axi_write_rx
  import axi_write_rx_pkg::*;
#(
  parameter int          ID_W    = 7,
  parameter logic [15:0] EXP_VID = 16'hB41A,
  parameter logic [7:0]  MAX_LEN = 8'd15
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [ID_W-1:0] I_AWID,
  input  logic [63:0]     I_AWADDR,
  input  logic [7:0]      I_AWLEN,
  input  logic [2:0]      I_AWSIZE,
  input  logic [1:0]      I_AWBURST,
  input  logic            I_AWVALID,
  output logic            O_AWREADY,
  input  logic [255:0]    I_WDATA,
  input  logic [31:0]     I_WSTRB,
  input  logic            I_WLAST,
  input  logic            I_WVALID,
  output logic            O_WREADY,
  output logic [ID_W-1:0] O_BID,
  output logic [1:0]      O_BRESP,
  output logic            O_BVALID,
  input  logic            I_BREADY,
  output logic [255:0]    O_PLD_DATA,
  output logic            O_PLD_FIRST,
  output logic            O_PLD_LAST,
  output logic            O_PLD_VALID,
  input  logic            I_PLD_READY,
  output logic [127:0]    O_HDR,
  output logic            O_HDR_VALID,
  output logic            O_MSG_DONE,
  output logic [2:0]      O_ASM_ERR
`ifdef AXI_WRITE_RX_STATS_EN
  ,
  output logic [31:0]     O_STAT_MSG,
  output logic [31:0]     O_STAT_ERR,
  output logic [31:0]     O_STAT_SLVERR
`endif
);

  bus_state_t      state;
  logic [ID_W-1:0] aw_id;
  logic [7:0]      aw_len;
  logic [7:0]      beat_cnt;
  logic            err;       // doubles as the drop flag for the rest of the burst
  logic            hdr_good;

  logic       in_data, first_beat, w_hs, b_hs, aw_hs, aw_bad;
  logic       beat0_good, hdr_good_now, new_err, asm_eval;
  logic [7:0] asm_fields;
  logic       unused_ok;

  assign unused_ok = ^{I_AWADDR, I_WSTRB};

  assign in_data     = (state == DATA);
  assign first_beat  = (beat_cnt == 8'd0);
  assign O_WREADY    = in_data & (I_PLD_READY | err);
  assign O_PLD_VALID = in_data & I_WVALID & ~err;
  assign O_PLD_DATA  = I_WDATA;
  assign O_PLD_FIRST = in_data & first_beat;
  assign O_PLD_LAST  = I_WLAST;

  assign w_hs  = I_WVALID & O_WREADY;
  assign aw_hs = I_AWVALID & O_AWREADY;
  assign b_hs  = O_BVALID & I_BREADY;

  assign aw_bad = (I_AWSIZE != AWSIZE_32B) | (I_AWBURST != BURST_INCR) | (I_AWLEN > MAX_LEN);

  // A single-beat burst must be judged on the header it is carrying right now.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    beat0_good   = 1'b0;
    hdr_good_now = hdr_good;
    asm_fields   = O_HDR[HDR_ASM_LSB +: 8];
    new_err      = I_WLAST & (beat_cnt != aw_len);
    beat0_good = (I_WDATA[HDR_FMT_LSB +: 3]  == FMT_VDM)
              && (I_WDATA[HDR_TYPE_LSB +: 2] == TYPE_MSG)
              && (I_WDATA[HDR_CODE_LSB +: 8] == MSG_CODE_VDM)
              && (I_WDATA[HDR_VID_LSB +: 16] == EXP_VID);
    if (first_beat) begin
      hdr_good_now = beat0_good;
      asm_fields   = I_WDATA[HDR_ASM_LSB +: 8];
      new_err      = new_err | ~beat0_good;
    end
  end

  assign asm_eval = in_data & w_hs & I_WLAST & hdr_good_now;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      O_AWREADY   <= 1'b0;
      O_BVALID    <= 1'b0;
      O_BRESP     <= BRESP_OKAY;
      O_BID       <= '0;
      O_HDR       <= '0;
      O_HDR_VALID <= 1'b0;
      aw_id       <= '0;
      aw_len      <= '0;
      beat_cnt    <= '0;
      err         <= 1'b0;
      hdr_good    <= 1'b0;
    end else begin
      O_HDR_VALID <= 1'b0;
      case (state)
        IDLE: begin
          O_AWREADY <= 1'b1;
          if (aw_hs) begin
            O_AWREADY <= 1'b0;
            aw_id     <= I_AWID;
            aw_len    <= I_AWLEN;
            beat_cnt  <= '0;
            err       <= aw_bad;
            hdr_good  <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
            if (first_beat) begin
              O_HDR       <= I_WDATA[127:0];
              O_HDR_VALID <= 1'b1;
              hdr_good    <= beat0_good;
            end
            if (new_err) err <= 1'b1;
            if (I_WLAST) begin
              O_BVALID <= 1'b1;
              O_BID    <= aw_id;
              O_BRESP  <= (err | new_err) ? BRESP_SLVERR : BRESP_OKAY;
              state    <= RESP;
            end
          end
        end
        RESP: begin
          if (b_hs) begin
            O_BVALID  <= 1'b0;
            O_AWREADY <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mctp_asm_check u_asm_check (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_eval     (asm_eval),
    .i_som_eom  (asm_fields[7:6]),
    .i_seq      (asm_fields[5:4]),
    .i_tag      (asm_fields[3:0]),
    .o_msg_done (O_MSG_DONE),
    .o_asm_err  (O_ASM_ERR)
  );

`ifdef AXI_WRITE_RX_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      O_STAT_MSG    <= '0;
      O_STAT_ERR    <= '0;
      O_STAT_SLVERR <= '0;
    end else begin
      if (O_MSG_DONE && O_STAT_MSG != 32'hFFFF_FFFF) O_STAT_MSG <= O_STAT_MSG + 32'd1;
      if (O_ASM_ERR != ASM_ERR_NONE && O_STAT_ERR != 32'hFFFF_FFFF) O_STAT_ERR <= O_STAT_ERR + 32'd1;
      if (b_hs && O_BRESP == BRESP_SLVERR && O_STAT_SLVERR != 32'hFFFF_FFFF)
        O_STAT_SLVERR <= O_STAT_SLVERR + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_write_rx.sv
// Directed self-checking bench for axi_write_rx: good messages, sequence/tag/
// restart errors, header and length errors, and backpressure on W and B.
`timescale 1ns/1ps
module tb_axi_write_rx;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic [6:0]   I_AWID;
  logic [63:0]  I_AWADDR;
  logic [7:0]   I_AWLEN;
  logic [2:0]   I_AWSIZE;
  logic [1:0]   I_AWBURST;
  logic         I_AWVALID;
  logic         O_AWREADY;
  logic [255:0] I_WDATA;
  logic [31:0]  I_WSTRB;
  logic         I_WLAST;
  logic         I_WVALID;
  logic         O_WREADY;
  logic [6:0]   O_BID;
  logic [1:0]   O_BRESP;
  logic         O_BVALID;
  logic         I_BREADY;
  logic [255:0] O_PLD_DATA;
  logic         O_PLD_FIRST;
  logic         O_PLD_LAST;
  logic         O_PLD_VALID;
  logic         I_PLD_READY;
  logic [127:0] O_HDR;
  logic         O_HDR_VALID;
  logic         O_MSG_DONE;
  logic [2:0]   O_ASM_ERR;

  always #5 i_clk = ~i_clk;

  axi_write_rx dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .I_AWID(I_AWID), .I_AWADDR(I_AWADDR), .I_AWLEN(I_AWLEN), .I_AWSIZE(I_AWSIZE),
    .I_AWBURST(I_AWBURST), .I_AWVALID(I_AWVALID), .O_AWREADY(O_AWREADY),
    .I_WDATA(I_WDATA), .I_WSTRB(I_WSTRB), .I_WLAST(I_WLAST), .I_WVALID(I_WVALID),
    .O_WREADY(O_WREADY), .O_BID(O_BID), .O_BRESP(O_BRESP), .O_BVALID(O_BVALID),
    .I_BREADY(I_BREADY), .O_PLD_DATA(O_PLD_DATA), .O_PLD_FIRST(O_PLD_FIRST),
    .O_PLD_LAST(O_PLD_LAST), .O_PLD_VALID(O_PLD_VALID), .I_PLD_READY(I_PLD_READY),
    .O_HDR(O_HDR), .O_HDR_VALID(O_HDR_VALID), .O_MSG_DONE(O_MSG_DONE), .O_ASM_ERR(O_ASM_ERR)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream observation, sampled on the falling edge away from input changes
  logic [255:0] pld_q[$];
  bit           first_q[$];
  int           done_cnt = 0;
  int           err_cnt  = 0;
  int           hdr_cnt  = 0;
  logic [2:0]   last_err = 3'd0;

  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (O_PLD_VALID && I_PLD_READY) begin
        pld_q.push_back(O_PLD_DATA);
        first_q.push_back(O_PLD_FIRST);
      end
      if (O_MSG_DONE) done_cnt++;
      if (O_HDR_VALID) hdr_cnt++;
      if (O_ASM_ERR != 3'd0) begin
        err_cnt++;
        last_err = O_ASM_ERR;
      end
    end
  end

  localparam logic [1:0] SE_M = 2'b00, SE_L = 2'b01, SE_S = 2'b10, SE_SG = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [15:0] VID = 16'hB41A;

  logic [255:0] bd [0:31];
  int           salt_ctr = 0;

  function automatic logic [127:0] mk_hdr(input logic [1:0] se, input logic [1:0] sq,
                                          input logic [3:0] tg, input logic [15:0] vid);
    logic [127:0] h;
    h = '0;
    h[127:126] = se;
    h[125:124] = sq;
    h[123:120] = tg;
    h[95:80]   = vid;
    h[63:56]   = 8'h7F;
    h[31:16]   = 16'hABCD;
    h[7:5]     = 3'b011;
    h[4:3]     = 2'b10;
    return h;
  endfunction

  task automatic send_aw(input logic [6:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] bst);
    int n = 0;
    I_AWID = id; I_AWLEN = len; I_AWSIZE = size; I_AWBURST = bst;
    I_AWADDR = 64'h0000_1000_0000_0040; I_AWVALID = 1'b1;
    while (!O_AWREADY && n < 50) begin @(posedge i_clk); #1; n++; end
    check("aw_accept", n < 50, 1);
    @(posedge i_clk); #1;
    I_AWVALID = 1'b0;
  endtask

  // mode 0: payload always ready; 1: ready toggles; 2: ready only for beat 0
  task automatic send_w(input int nbeats, input int mode);
    int i = 0;
    int cyc = 0;
    while (i < nbeats && cyc < 200) begin
      I_WDATA = bd[i]; I_WLAST = (i == nbeats - 1); I_WVALID = 1'b1;
      I_PLD_READY = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : (i == 0);
      #1;
      if (mode == 2 && i > 0) begin
        check("drop_wready", O_WREADY, 1);
        check("drop_pld_valid", O_PLD_VALID, 0);
      end
      if (O_WREADY) i++;
      @(posedge i_clk); #1;
      cyc++;
    end
    check("w_complete", i, nbeats);
    I_WVALID = 1'b0; I_WLAST = 1'b0; I_PLD_READY = 1'b1;
  endtask

  task automatic take_b(input int bdelay, output logic [6:0] bid, output logic [1:0] bresp);
    int n = 0;
    while (!O_BVALID && n < 50) begin @(posedge i_clk); #1; n++; end
    check("b_arrive", n < 50, 1);
    for (int k = 0; k < bdelay; k++) begin
      check("bvalid_hold", O_BVALID, 1);
      check("awready_in_resp", O_AWREADY, 0);
      @(posedge i_clk); #1;
    end
    bid = O_BID; bresp = O_BRESP;
    I_BREADY = 1'b1;
    @(posedge i_clk); #1;
    I_BREADY = 1'b0;
  endtask

  task automatic burst(input logic [6:0] id, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] bst, input logic [127:0] hdr, input int nbeats,
                       input int mode, input int bdelay, input logic [1:0] exp_resp,
                       input int exp_fwd);
    logic [6:0]  bid;
    logic [1:0]  bresp;
    logic [31:0] salt;
    salt_ctr++;
    salt = 32'hA500_0000 + 32'(salt_ctr) * 32'h0101_0101;
    bd[0] = {{4{salt}}, hdr};
    for (int i = 1; i < 32; i++) bd[i] = {8{salt + 32'(i)}};
    pld_q.delete();
    first_q.delete();
    send_aw(id, len, size, bst);
    send_w(nbeats, mode);
    take_b(bdelay, bid, bresp);
    check("bid", bid, id);
    check("bresp", bresp, exp_resp);
    check("pld_beats", pld_q.size(), exp_fwd);
    for (int i = 0; i < exp_fwd && i < pld_q.size(); i++) begin
      check("pld_data", pld_q[i], bd[i]);
      check("pld_first", first_q[i], i == 0);
    end
    check("hdr_latched", O_HDR, hdr);
  endtask

  int d0, e0, h0;

  initial begin
    i_reset = 1'b1;
    I_AWID = '0; I_AWADDR = '0; I_AWLEN = '0; I_AWSIZE = '0; I_AWBURST = '0; I_AWVALID = 1'b0;
    I_WDATA = '0; I_WSTRB = '1; I_WLAST = 1'b0; I_WVALID = 1'b0; I_BREADY = 1'b0;
    I_PLD_READY = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_awready", O_AWREADY, 0);
    check("rst_wready", O_WREADY, 0);
    check("rst_bvalid", O_BVALID, 0);
    check("rst_bresp", O_BRESP, 0);
    check("rst_bid", O_BID, 0);
    check("rst_pld_valid", O_PLD_VALID, 0);
    check("rst_hdr", O_HDR, 0);
    check("rst_hdr_valid", O_HDR_VALID, 0);
    check("rst_msg_done", O_MSG_DONE, 0);
    check("rst_asm_err", O_ASM_ERR, 0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    check("idle_awready", O_AWREADY, 1);

    // Good four-packet message, tag 6
    d0 = done_cnt; e0 = err_cnt; h0 = hdr_cnt;
    burst(7'h11, 8'd3, 3'd5, 2'b01, mk_hdr(SE_S, 2'd0, 4'd6, VID), 4, 0, 0, OKAY, 4);
    burst(7'h12, 8'd3, 3'd5, 2'b01, mk_hdr(SE_M, 2'd1, 4'd6, VID), 4, 0, 0, OKAY, 4);
    burst(7'h13, 8'd3, 3'd5, 2'b01, mk_hdr(SE_M, 2'd2, 4'd6, VID), 4, 0, 0, OKAY, 4);
    check("msg_not_done_early", done_cnt - d0, 0);
    burst(7'h14, 8'd3, 3'd5, 2'b01, mk_hdr(SE_L, 2'd3, 4'd6, VID), 4, 0, 0, OKAY, 4);
    check("msg_done_once", done_cnt - d0, 1);
    check("good_no_asm_err", err_cnt - e0, 0);
    check("hdr_valid_pulses", hdr_cnt - h0, 4);

    // Sequence gap, then an orphan L
    e0 = err_cnt;
    burst(7'h21, 8'd3, 3'd5, 2'b01, mk_hdr(SE_S, 2'd0, 4'd6, VID), 4, 0, 0, OKAY, 4);
    burst(7'h22, 8'd3, 3'd5, 2'b01, mk_hdr(SE_M, 2'd2, 4'd6, VID), 4, 0, 0, OKAY, 4);
    check("seq_err_count", err_cnt - e0, 1);
    check("seq_err_code", last_err, 3'd2);
    burst(7'h23, 8'd3, 3'd5, 2'b01, mk_hdr(SE_L, 2'd3, 4'd6, VID), 4, 0, 0, OKAY, 4);
    check("orphan_err_count", err_cnt - e0, 2);
    check("orphan_err_code", last_err, 3'd4);

    // Restart with a new tag, which then completes (seq wraps through 1, 2)
    d0 = done_cnt; e0 = err_cnt;
    burst(7'h31, 8'd3, 3'd5, 2'b01, mk_hdr(SE_S, 2'd0, 4'd6, VID), 4, 0, 0, OKAY, 4);
    burst(7'h32, 8'd3, 3'd5, 2'b01, mk_hdr(SE_S, 2'd0, 4'd5, VID), 4, 0, 0, OKAY, 4);
    check("restart_err_count", err_cnt - e0, 1);
    check("restart_err_code", last_err, 3'd1);
    burst(7'h33, 8'd3, 3'd5, 2'b01, mk_hdr(SE_M, 2'd1, 4'd5, VID), 4, 0, 0, OKAY, 4);
    burst(7'h34, 8'd3, 3'd5, 2'b01, mk_hdr(SE_L, 2'd2, 4'd5, VID), 4, 0, 0, OKAY, 4);
    check("restart_msg_done", done_cnt - d0, 1);
    check("restart_no_more_err", err_cnt - e0, 1);

    // Wrong vendor ID: beat 0 forwarded, rest dropped while payload stalls
    d0 = done_cnt; e0 = err_cnt;
    burst(7'h41, 8'd3, 3'd5, 2'b01, mk_hdr(SE_S, 2'd0, 4'd1, 16'h1234), 4, 2, 0, SLVERR, 1);
    check("badvid_no_done", done_cnt - d0, 0);
    check("badvid_no_asm_err", err_cnt - e0, 0);

    // Illegal AW attributes: whole burst dropped
    burst(7'h42, 8'd1, 3'd4, 2'b01, mk_hdr(SE_SG, 2'd0, 4'd0, VID), 2, 0, 0, SLVERR, 0);
    burst(7'h43, 8'd1, 3'd5, 2'b10, mk_hdr(SE_SG, 2'd0, 4'd0, VID), 2, 0, 0, SLVERR, 0);
    burst(7'h44, 8'd16, 3'd5, 2'b01, mk_hdr(SE_SG, 2'd0, 4'd0, VID), 17, 0, 0, SLVERR, 0);
    burst(7'h45, 8'd15, 3'd5, 2'b01, mk_hdr(SE_SG, 2'd0, 4'd0, VID), 16, 0, 0, OKAY, 16);

    // Early WLAST, then a normal single-beat SG burst
    burst(7'h7F, 8'd3, 3'd5, 2'b01, mk_hdr(SE_SG, 2'd0, 4'd2, VID), 2, 0, 0, SLVERR, 2);
    d0 = done_cnt; e0 = err_cnt;
    burst(7'h00, 8'd0, 3'd5, 2'b01, mk_hdr(SE_SG, 2'd1, 4'd3, VID), 1, 0, 0, OKAY, 1);
    check("sg_single_done", done_cnt - d0, 1);
    check("sg_single_no_err", err_cnt - e0, 0);

    // Payload ready toggling, B held off for 5 cycles
    burst(7'h5A, 8'd3, 3'd5, 2'b01, mk_hdr(SE_S, 2'd0, 4'd2, VID), 4, 1, 5, OKAY, 4);
    check("awready_after_b", O_AWREADY, 1);
    check("bvalid_dropped", O_BVALID, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/axi_write_rx.md
Name: axi_write_rx

Overview:
- AXI4 write responder (slave) that terminates MCTP-over-PCIe VDM bursts: one 256-bit burst per packet, with the 128-bit TLP header in beat 0 bits [127:0].
- Accepts AW/W, returns B, and streams beats to a downstream payload interface.
- Validates the header and tracks message assembly using SOM/EOM, packet sequence and tag.
- Sits between the AXI interconnect and the MCTP message assembler/buffer.

Parameters:
- ID_W, 7, AWID/BID width
- EXP_VID, 16'hB41A, required vendor ID (header[95:80])
- MAX_LEN, 8'd15, largest AWLEN accepted without SLVERR

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- I_AWID  in  ID_W  write ID
- I_AWADDR  in  64  address; not decoded
- I_AWLEN  in  8  beats-1
- I_AWSIZE  in  3  must be 5
- I_AWBURST  in  2  must be INCR (01)
- I_AWVALID  in  1  AW valid
- O_AWREADY  out  1  AW ready
- I_WDATA  in  256  write data
- I_WSTRB  in  32  ignored
- I_WLAST  in  1  last beat
- I_WVALID  in  1  W valid
- O_WREADY  out  1  W ready
- O_BID  out  ID_W  echo of captured AWID
- O_BRESP  out  2  00 OKAY / 10 SLVERR
- O_BVALID  out  1  B valid
- I_BREADY  in  1  B ready
- O_PLD_DATA  out  256  beat data (== I_WDATA)
- O_PLD_FIRST  out  1  beat 0 of the burst
- O_PLD_LAST  out  1  == I_WLAST
- O_PLD_VALID  out  1  payload valid
- I_PLD_READY  in  1  payload ready
- O_HDR  out  128  header latched from beat 0
- O_HDR_VALID  out  1  1-cycle pulse when the header is latched
- O_MSG_DONE  out  1  1-cycle pulse when a message completes in order
- O_ASM_ERR  out  3  1-cycle error code: 0 none, 1 restart, 2 seq, 3 tag, 4 orphan

Behaviour:
- Reset values: all ready/valid/pulse outputs 0, O_BRESP 0, O_BID 0, O_HDR 0; FSM IDLE; assembler ASM_IDLE.
- Reset mid-burst abandons the burst; no B response is issued.
- Bus FSM states: IDLE, DATA, RESP.
- IDLE:
  - O_AWREADY=1 (registered).
  - On AWVALID: capture AWID, AWLEN; clear beat count and err; go to DATA.
  - Set err if AWSIZE!=5, AWBURST!=01, or AWLEN>MAX_LEN.
- DATA:
  - O_WREADY = I_PLD_READY | drop. drop = err latched.
  - O_PLD_VALID = I_WVALID & !drop. Both are combinational pass-through, zero latency.
  - Beat 0 handshake:
    - Latch O_HDR = I_WDATA[127:0]; pulse O_HDR_VALID the next cycle.
    - Set drop/err if fmt [7:5]!=3'b011, type [4:3]!=2'b10, msg code [63:56]!=8'h7F, or vendor [95:80]!=EXP_VID.
    - Header errors arise after beat 0 is forwarded; drop applies from beat 1.
  - Beat count saturates at 255.
  - WLAST with count!=AWLEN sets err.
  - Go to RESP on the WLAST handshake only.
- RESP:
  - O_BVALID=1, O_BID=captured ID, O_BRESP = err ? 10 : 00.
  - Hold until BREADY, then go to IDLE.
  - Exactly one B per AW.
- Assembly check (on a good header only, evaluated at the WLAST handshake):
  - Fields: som_eom=hdr[127:126], seq=hdr[125:124], tag=hdr[123:120].
  - S_PKT (10):
    - If ASM_ACTIVE, flag restart (code 1).
    - Either way, store tag, exp_seq=seq+1 (mod 4), go to ASM_ACTIVE.
  - M_PKT (00): requires ASM_ACTIVE and tag match and seq==exp_seq.
    - Success: exp_seq+1.
    - Failure: code 4 (idle), 3 (tag) or 2 (seq); go to ASM_IDLE.
  - L_PKT (01): same checks as M_PKT. Success pulses O_MSG_DONE and returns to ASM_IDLE.
  - SG_PKT (11): pulses O_MSG_DONE. If ASM_ACTIVE, also flag restart; go to ASM_IDLE.
  - Sequence wraps 3->0.
  - Assembly errors never change BRESP.
- AWVALID is ignored outside IDLE (single outstanding burst).

Optional Feature:
- AXI_WRITE_RX_STATS_EN defined:
  - Adds outputs O_STAT_MSG[31:0] (count of O_MSG_DONE), O_STAT_ERR[31:0] (count of nonzero O_ASM_ERR) and O_STAT_SLVERR[31:0].
  - Counters saturate at 32'hFFFFFFFF and are cleared by reset.
- Undefined: these ports and counters are absent.

Decomposition:
- Package axi_write_rx_pkg:
  - S_PKT/M_PKT/L_PKT/SG_PKT encodings.
  - Header field bit positions.
  - Fmt/type/msg-code constants.
  - BRESP codes.
  - ASM_ERR codes.
  - Bus FSM state enum.
- Sub-module mctp_asm_check: assembler FSM, tag/seq registers, O_MSG_DONE/O_ASM_ERR.
- The top level holds the AXI FSM and header capture.

Test Plan:
- Good message, tag 6, AWLEN=3: S seq0, M seq1, M seq2, L seq3 -> 4 OKAY B responses, 16 payload beats, one O_MSG_DONE after the 4th burst, O_ASM_ERR stays 0.
- S seq0 tag 6 then M seq2 tag 6 -> O_ASM_ERR=2 on the 2nd burst, BRESP OKAY; a following L seq3 gives O_ASM_ERR=4.
- S tag 6 then S tag 5 -> O_ASM_ERR=1; the new message with tag 5 completes with M seq1 and L seq2.
- Vendor ID 16'h1234 in beat 0 -> BRESP=10; beats 1-3 not forwarded; O_WREADY=1 with I_PLD_READY=0.
- AWLEN=3 with WLAST on beat 1 -> BRESP=10 after beat 1; next AW accepted normally.
- I_PLD_READY toggled 1/0 each cycle and I_BREADY delayed 5 cycles -> no beat lost or duplicated, O_BVALID held 5 cycles, O_AWREADY stays 0 until after the B handshake.
